// File: rtl/mvm_scheduler_pkg.sv
// Shared types and constants for the matrix-vector scheduler.
package mvm_scheduler_pkg;

  localparam int DATA_W        = 8;
  localparam int N_MAX_DEFAULT = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DRAIN, EMIT, FINISH
  } sched_state_t;

  // A dimension is usable when it is non-zero and fits the stored matrix.
  function automatic logic dim_legal(input int d, input int nmax);
    return (d >= 1) && (d <= nmax);
  endfunction

endpackage

// File: rtl/mvm_scheduler_addr_gen.sv
// Row/column counters and RAM address generation for mvm_scheduler.
// 'ahead' presents the next column's address (prefetch during RUN);
// 'issue' gates the addresses, so they read 0 whenever no read is wanted.
module mvm_addr_gen
  import mvm_scheduler_pkg::*;
#(
  parameter  int N_MAX = N_MAX_DEFAULT,
  localparam int DIMW  = $clog2(N_MAX+1),
  localparam int RW    = $clog2(N_MAX),
  localparam int AW    = $clog2(N_MAX*N_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIMW-1:0] dim,
  input  logic            clear,
  input  logic            step_col,
  input  logic            step_row,
  input  logic            ahead,
  input  logic            issue,
  output logic [RW-1:0]   row,
  output logic [RW-1:0]   col,
  output logic [AW-1:0]   mat_addr,
  output logic [AW-1:0]   vec_addr,
  output logic            last_col,
  output logic            last_row
);

  logic [RW-1:0] col_sel;

  // Counters: a new row always restarts at column 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step_row) begin
      row <= row + RW'(1);
      col <= '0;
    end else if (step_col) begin
      col <= col + RW'(1);
    end
  end

  // Address and last-element flags.
  always_comb begin
    col_sel  = ahead ? col + RW'(1) : col;
    mat_addr = issue ? AW'(row) * AW'(N_MAX) + AW'(col_sel) : '0;
    vec_addr = issue ? AW'(col_sel) : '0;
    last_col = (DIMW'(col) == dim - DIMW'(1));
    last_row = (DIMW'(row) == dim - DIMW'(1));
  end

endmodule

// File: rtl/mvm_scheduler.sv
// Sequences a shared MAC PE to compute y = M*v one row at a time.
// Optional feature: define MVM_SCHED_PERF_EN to add the perf_cycles counter.
module mvm_scheduler
  import mvm_scheduler_pkg::*;
#(
  parameter  int DW    = DATA_W,
  parameter  int N_MAX = N_MAX_DEFAULT,
  localparam int DIMW  = $clog2(N_MAX+1),
  localparam int RW    = $clog2(N_MAX),
  localparam int AW    = $clog2(N_MAX*N_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DIMW-1:0] dim,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   mat_addr,
  input  logic [DW-1:0]   mat_data,
  output logic [RW-1:0]   vec_addr,
  input  logic [DW-1:0]   vec_data,
  output logic            pe_enable,
  output logic [DW-1:0]   pe_a,
  output logic [DW-1:0]   pe_b,
  output logic            pe_retro,
  output logic [DW-1:0]   pe_prev,
  input  logic [DW-1:0]   pe_out,
  input  logic            pe_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [RW-1:0]   res_idx
`ifdef MVM_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  sched_state_t    state, state_nx;
  logic [DIMW-1:0] dim_q;
  logic            accept, legal;
  logic            clear, step_col, step_row, ahead, issue;
  logic [RW-1:0]   row, col;
  logic [AW-1:0]   vec_addr_full;
  logic            last_col, last_row;

  assign legal  = dim_legal(int'(dim), N_MAX);
  assign accept = (state == IDLE) && start && legal;

  mvm_addr_gen #(.N_MAX(N_MAX)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .dim      (dim_q),
    .clear    (clear),
    .step_col (step_col),
    .step_row (step_row),
    .ahead    (ahead),
    .issue    (issue),
    .row      (row),
    .col      (col),
    .mat_addr (mat_addr),
    .vec_addr (vec_addr_full),
    .last_col (last_col),
    .last_row (last_row)
  );

  // The column index never exceeds N_MAX-1, so the upper bits are always 0.
  assign vec_addr = vec_addr_full[RW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (last_col) state_nx = DRAIN;
      DRAIN:   if (pe_done) state_nx = EMIT;
      EMIT:    if (res_ready) state_nx = last_row ? FINISH : LOAD;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs and counter controls decoded from the current state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FINISH);
    res_valid = (state == EMIT);
    pe_enable = 1'b0;
    pe_a      = '0;
    pe_b      = '0;
    pe_retro  = 1'b0;
    pe_prev   = '0;
    clear     = accept;
    step_col  = (state == RUN) && !last_col;
    step_row  = (state == EMIT) && res_ready && !last_row;
    ahead     = (state == RUN);
    issue     = (state == LOAD) || ((state == RUN) && !last_col);
    if (state == RUN) begin
      pe_enable = 1'b1;
      pe_a      = mat_data;
      pe_b      = vec_data;
      pe_retro  = (col != '0);
      pe_prev   = pe_out;
    end
  end

  // Latched dimension, captured row result and illegal-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dim_q    <= '0;
      res_data <= '0;
      res_idx  <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !legal;
      if (accept) dim_q <= dim;
      if (state == DRAIN && pe_done) begin
        res_data <= pe_out;
        res_idx  <= row;
      end
    end
  end

`ifdef MVM_SCHED_PERF_EN
  // Busy-cycle counter: restarts on each accepted start, saturates, holds when idle.
  always_ff @(posedge clk) begin
    if (rst)                                perf_cycles <= '0;
    else if (accept)                        perf_cycles <= '0;
    else if (busy && perf_cycles != '1)     perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mvm_scheduler.sv
// Self-checking bench for mvm_scheduler: behavioural PE and sync RAMs,
// reference dot products computed directly from M and v.
module tb_mvm_scheduler;
  localparam int DW = 8, N = 8;

  logic       clk = 0, rst = 1, start = 0, res_ready = 1;
  logic [3:0] dim = 0;
  logic       busy, done, err, pe_enable, pe_retro, pe_done, res_valid;
  logic [5:0] mat_addr;
  logic [2:0] vec_addr, res_idx;
  logic [7:0] mat_data, vec_data, pe_a, pe_b, pe_prev, pe_out, res_data;
`ifdef MVM_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  logic [7:0] mat_mem [N*N];
  logic [7:0] vec_mem [N];
  int mm [N][N];
  int vv [N];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mvm_scheduler #(.DW(DW), .N_MAX(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dim(dim), .busy(busy), .done(done), .err(err),
    .mat_addr(mat_addr), .mat_data(mat_data), .vec_addr(vec_addr), .vec_data(vec_data),
    .pe_enable(pe_enable), .pe_a(pe_a), .pe_b(pe_b), .pe_retro(pe_retro), .pe_prev(pe_prev),
    .pe_out(pe_out), .pe_done(pe_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
`ifdef MVM_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Sync-read RAMs, one cycle of latency.
  always @(posedge clk) begin
    mat_data <= mat_mem[mat_addr];
    vec_data <= vec_mem[vec_addr];
  end

  // Behavioural MAC PE with a registered result.
  always @(posedge clk) begin
    if (rst) begin
      pe_out  <= 0;
      pe_done <= 0;
    end else begin
      pe_done <= pe_enable;
      if (pe_enable) pe_out <= pe_retro ? 8'(pe_prev + pe_a * pe_b) : 8'(pe_a * pe_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Dot product of row i with v, wrapped to DW bits.
  function automatic int ref_row(input int i, input int d);
    int s = 0;
    for (int k = 0; k < d; k++) s += mm[i][k] * vv[k];
    return s % 256;
  endfunction

  // Copy the model matrices into the RAMs; unused cells get noise.
  task automatic load_mem();
    for (int i = 0; i < N; i++) begin
      vec_mem[i] = 8'(vv[i]);
      for (int j = 0; j < N; j++) mat_mem[i*N+j] = 8'(mm[i][j]);
    end
  endtask

  task automatic fill_rand(input int d);
    for (int i = 0; i < N; i++) begin
      vv[i] = $urandom_range(0, 255);
      for (int j = 0; j < N; j++) mm[i][j] = $urandom_range(0, 255);
    end
    load_mem();
  endtask

  task automatic set_test1();
    fill_rand(N);
    mm[0][0] = 1; mm[0][1] = 2; mm[1][0] = 3; mm[1][1] = 4;
    vv[0] = 5; vv[1] = 6;
    load_mem();
  endtask

  // One full operation; row 0 is backpressured for 'stall' cycles.
  task automatic run_mvm(input int d, input int stall, input string tag);
    int cyc, got, done_cyc, retro_hi, stall_left;
    logic [7:0] held_d;
    logic [2:0] held_i;
    bit seen;
    @(negedge clk);
    dim = 4'(d); start = 1; res_ready = 1;
    @(negedge clk);
    start = 0;
    cyc = 1; got = 0; done_cyc = 0; retro_hi = 0; stall_left = stall; seen = 0;
    held_d = 0; held_i = 0;
    chk({tag, "_busy"}, busy, 1);
    while (done_cyc == 0 && cyc < 400) begin
      if (pe_retro) retro_hi++;
      if (done) done_cyc = cyc;
      else if (res_valid) begin
        if (got == 0 && stall_left > 0) begin
          if (!seen) begin
            held_d = res_data; held_i = res_idx; seen = 1;
          end else begin
            chk({tag, "_hold_data"}, res_data, held_d);
            chk({tag, "_hold_idx"}, res_idx, held_i);
          end
          chk({tag, "_stall_pe_en"}, pe_enable, 0);
          res_ready = 0;
          stall_left--;
        end else begin
          res_ready = 1;
          chk({tag, "_data"}, res_data, ref_row(got, d));
          chk({tag, "_idx"}, res_idx, got);
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, done_cyc, d*(d+3) + 1 + stall);
    chk({tag, "_rows"}, got, d);
    if (d == 1) chk({tag, "_retro"}, retro_hi, 0);
`ifdef MVM_SCHED_PERF_EN
    chk({tag, "_perf"}, perf_cycles, d*(d+3) + 1 + stall);
`endif
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    bit seen_done;
    for (int i = 0; i < N; i++) vec_mem[i] = 0;
    for (int i = 0; i < N*N; i++) mat_mem[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pe_en", pe_enable, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_addr", mat_addr, 0);
    chk("rst_res", res_data, 0);
    rst = 0;

    // Basic 2x2.
    set_test1();
    run_mvm(2, 0, "t1");

    // 1x1: no accumulation.
    fill_rand(N);
    mm[0][0] = 7; vv[0] = 3;
    load_mem();
    run_mvm(1, 0, "t2");

    // Wrap modulo 2^DW.
    fill_rand(N);
    mm[0][0] = 16; mm[0][1] = 1; mm[1][0] = 0; mm[1][1] = 0;
    vv[0] = 16; vv[1] = 0;
    load_mem();
    run_mvm(2, 0, "t3");

    // Backpressure on row 0.
    set_test1();
    run_mvm(2, 5, "t4");

    // Illegal dimensions.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      dim = (t == 0) ? 4'd0 : 4'(N + 1);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("t5_err", err, 1);
      chk("t5_busy", busy, 0);
      chk("t5_addr", mat_addr, 0);
      @(negedge clk);
      chk("t5_err_pulse", err, 0);
      chk("t5_busy2", busy, 0);
    end

    // Reset during RUN of row 1, then a clean rerun.
    set_test1();
    @(negedge clk);
    dim = 2; start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    chk("t6_in_run", pe_enable, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_pe_en", pe_enable, 0);
    chk("t6_valid", res_valid, 0);
    chk("t6_res", res_data, 0);
    chk("t6_addr", mat_addr, 0);
    chk("t6_done", done, 0);
    rst = 0;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("t6_no_done", seen_done, 0);
    run_mvm(2, 0, "t6_rerun");

    // Randomized dimensions, data and backpressure.
    for (int r = 0; r < 8; r++) begin
      int d;
      d = $urandom_range(1, N);
      fill_rand(d);
      run_mvm(d, $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
